// File: rtl/pixel_window_sequencer.sv
// Raster-order sliding-window sequencer: tracks channel/column/row of the incoming stream and drives line-buffer addresses.
// Defining PIXWIN_FRAME_STATUS_EN adds the frame_done pulse and the per-frame win_count outputs.

`ifndef LOG2
`define LOG2(n) (((n) <= 2) ? 1 : $clog2(n))
`endif

module pixel_window_sequencer #(
  parameter int FILTER_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int STRIDE_X     = 1,
  parameter int STRIDE_Y     = 1,
  parameter int CHANNELS     = 1,
  localparam int DEPTH  = (IMAGE_WIDTH - FILTER_SIZE + 1) * CHANNELS,
  localparam int ADDR_W = `LOG2(DEPTH),
  localparam int CH_W   = `LOG2(CHANNELS)
`ifdef PIXWIN_FRAME_STATUS_EN
  , localparam int WIN_COUNT = ((IMAGE_WIDTH - FILTER_SIZE) / STRIDE_X + 1) *
                               ((IMAGE_HEIGHT - FILTER_SIZE) / STRIDE_Y + 1)
  , localparam int WC_W = `LOG2(WIN_COUNT + 1)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              valid,
  output logic [CH_W-1:0]   ch_out
`ifdef PIXWIN_FRAME_STATUS_EN
  , output logic            frame_done
  , output logic [WC_W-1:0] win_count
`endif
);

  localparam int X_W  = `LOG2(IMAGE_WIDTH);
  localparam int Y_W  = `LOG2(IMAGE_HEIGHT);
  localparam int PX_W = `LOG2(STRIDE_X);
  localparam int PY_W = `LOG2(STRIDE_Y);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMAGE_WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMAGE_HEIGHT - 1);
  localparam logic [X_W-1:0]    X_WIN     = X_W'(FILTER_SIZE - 1);
  localparam logic [Y_W-1:0]    Y_WIN     = Y_W'(FILTER_SIZE - 1);
  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(STRIDE_X - 1);
  localparam logic [PY_W-1:0]   PY_LAST   = PY_W'(STRIDE_Y - 1);

  logic [CH_W-1:0]   ch, ch_nxt;
  logic [X_W-1:0]    x, x_nxt;
  logic [Y_W-1:0]    y, y_nxt;
  logic [PX_W-1:0]   px, px_nxt;
  logic [PY_W-1:0]   py, py_nxt;
  logic [ADDR_W-1:0] wr_nxt;
  logic              ch_last, x_last, y_last, at_window;

  assign ch_last = (ch == CH_LAST);
  assign x_last  = (x == X_LAST);
  assign y_last  = (y == Y_LAST);

  // Phase counters stay at 0 until the axis reaches the first window column/row, so phase 0 marks a stride hit.
  assign at_window = (x >= X_WIN) && (y >= Y_WIN) && (px == '0) && (py == '0);

  assign rd_addr = (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ch_nxt = ch + 1'b1;
    x_nxt  = x;
    y_nxt  = y;
    px_nxt = px;
    py_nxt = py;
    wr_nxt = (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;
    if (ch_last) begin
      ch_nxt = '0;
      if (x_last) begin
        x_nxt  = '0;
        px_nxt = '0;
        if (y_last) begin
          y_nxt  = '0;
          py_nxt = '0;
        end else begin
          y_nxt  = y + 1'b1;
          py_nxt = (y < Y_WIN || py == PY_LAST) ? '0 : py + 1'b1;
        end
      end else begin
        x_nxt  = x + 1'b1;
        px_nxt = (x < X_WIN || px == PX_LAST) ? '0 : px + 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments and an asynchronous active-low reset so it clears mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch      <= '0;
      x       <= '0;
      y       <= '0;
      px      <= '0;
      py      <= '0;
      wr_addr <= '0;
      valid   <= 1'b0;
      ch_out  <= '0;
    end else begin
      valid <= clk_en && at_window;
      if (clk_en) begin
        ch      <= ch_nxt;
        x       <= x_nxt;
        y       <= y_nxt;
        px      <= px_nxt;
        py      <= py_nxt;
        wr_addr <= wr_nxt;
        ch_out  <= ch;
      end
    end
  end

`ifdef PIXWIN_FRAME_STATUS_EN
  logic first_sample, last_sample;

  assign first_sample = (ch == '0) && (x == '0) && (y == '0);
  assign last_sample  = ch_last && x_last && y_last;

  // The count includes the window being flagged on the same edge, so it is final alongside frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      win_count  <= '0;
    end else begin
      frame_done <= clk_en && last_sample;
      if (clk_en)
        win_count <= (first_sample ? '0 : win_count) + WC_W'(at_window && ch_last);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_window_sequencer.sv
// Directed bench for pixel_window_sequencer: three configurations (plain 5x5, stride-2 5x5, 3-channel 4x4) share one stimulus stream.
// Frame-status checks compile in when PIXWIN_FRAME_STATUS_EN is defined.

module tb_pixel_window_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] rd_b, wr_b;
  logic       valid_b;
  logic [0:0] ch_b;
  logic [1:0] rd_s, wr_s;
  logic       valid_s;
  logic [0:0] ch_s;
  logic [2:0] rd_c, wr_c;
  logic       valid_c;
  logic [1:0] ch_c;
`ifdef PIXWIN_FRAME_STATUS_EN
  logic       fd_b, fd_s, fd_c;
  logic [3:0] wc_b;
  logic [2:0] wc_s, wc_c;
`endif

  pixel_window_sequencer #(
    .FILTER_SIZE(3), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5),
    .STRIDE_X(1), .STRIDE_Y(1), .CHANNELS(1)
  ) u_base (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .rd_addr(rd_b), .wr_addr(wr_b), .valid(valid_b), .ch_out(ch_b)
`ifdef PIXWIN_FRAME_STATUS_EN
    , .frame_done(fd_b), .win_count(wc_b)
`endif
  );

  pixel_window_sequencer #(
    .FILTER_SIZE(3), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5),
    .STRIDE_X(2), .STRIDE_Y(2), .CHANNELS(1)
  ) u_strd (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .rd_addr(rd_s), .wr_addr(wr_s), .valid(valid_s), .ch_out(ch_s)
`ifdef PIXWIN_FRAME_STATUS_EN
    , .frame_done(fd_s), .win_count(wc_s)
`endif
  );

  pixel_window_sequencer #(
    .FILTER_SIZE(3), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .STRIDE_X(1), .STRIDE_Y(1), .CHANNELS(3)
  ) u_chan (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .rd_addr(rd_c), .wr_addr(wr_c), .valid(valid_c), .ch_out(ch_c)
`ifdef PIXWIN_FRAME_STATUS_EN
    , .frame_done(fd_c), .win_count(wc_c)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected window hit for the n-th sample since reset, from raster position.
  function automatic bit win_base(input int n);
    int k = n % 25;
    return (k % 5 >= 2) && (k / 5 >= 2);
  endfunction

  function automatic bit win_strd(input int n);
    int k = n % 25;
    return win_base(n) && ((k % 5) % 2 == 0) && ((k / 5) % 2 == 0);
  endfunction

  function automatic bit win_chan(input int n);
    int p = (n % 48) / 3;
    return (p % 4 >= 2) && (p / 4 >= 2);
  endfunction

  task automatic tick(input bit en);
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid_b"}, valid_b, 0);
    check({tag, "_wr_b"}, wr_b, 0);
    check({tag, "_rd_b"}, rd_b, 1);
    check({tag, "_ch_b"}, ch_b, 0);
    check({tag, "_valid_s"}, valid_s, 0);
    check({tag, "_wr_s"}, wr_s, 0);
    check({tag, "_rd_s"}, rd_s, 1);
    check({tag, "_valid_c"}, valid_c, 0);
    check({tag, "_wr_c"}, wr_c, 0);
    check({tag, "_rd_c"}, rd_c, 1);
    check({tag, "_ch_c"}, ch_c, 0);
`ifdef PIXWIN_FRAME_STATUS_EN
    check({tag, "_fd_b"}, fd_b, 0);
    check({tag, "_wc_b"}, wc_b, 0);
    check({tag, "_fd_c"}, fd_c, 0);
    check({tag, "_wc_c"}, wc_c, 0);
`endif
  endtask

  // Feeds `target` samples from a freshly reset state, optionally with idle gaps, checking every cycle.
  task automatic run(input string tag, input int target, input bit gaps, input int budget);
    int n, cyc, first_v, kb, kc;
    bit en;
    int cnt_b[8];
    int cnt_s[8];
    int cnt_c[8];
    n = 0;
    cyc = 0;
    first_v = -1;
    for (int i = 0; i < 8; i++) begin
      cnt_b[i] = 0;
      cnt_s[i] = 0;
      cnt_c[i] = 0;
    end
    while (n < target && cyc < budget) begin
      en = gaps ? ($urandom_range(2, 0) != 0) : 1'b1;
      tick(en);
      cyc++;
      if (en) begin
        kb = n % 25;
        kc = n % 48;
        check($sformatf("%s_valid_b[%0d]", tag, n), valid_b, win_base(n));
        check($sformatf("%s_valid_s[%0d]", tag, n), valid_s, win_strd(n));
        check($sformatf("%s_valid_c[%0d]", tag, n), valid_c, win_chan(n));
        if (win_chan(n))
          check($sformatf("%s_ch_c[%0d]", tag, n), ch_c, kc % 3);
        if (valid_b && first_v < 0) first_v = n;
        cnt_b[n / 25] += int'(valid_b);
        cnt_s[n / 25] += int'(valid_s);
        cnt_c[n / 48] += int'(valid_c);
`ifdef PIXWIN_FRAME_STATUS_EN
        check($sformatf("%s_fd_b[%0d]", tag, n), fd_b, kb == 24);
        check($sformatf("%s_fd_s[%0d]", tag, n), fd_s, kb == 24);
        check($sformatf("%s_fd_c[%0d]", tag, n), fd_c, kc == 47);
        if (kb == 24) begin
          check($sformatf("%s_wc_b_end[%0d]", tag, n), wc_b, 9);
          check($sformatf("%s_wc_s_end[%0d]", tag, n), wc_s, 4);
        end
        if (kb == 0) check($sformatf("%s_wc_b_clr[%0d]", tag, n), wc_b, 0);
        if (kc == 47) check($sformatf("%s_wc_c_end[%0d]", tag, n), wc_c, 4);
`endif
        n++;
        check($sformatf("%s_wr_b[%0d]", tag, n), wr_b, n % 3);
        check($sformatf("%s_rd_b[%0d]", tag, n), rd_b, (n + 1) % 3);
        check($sformatf("%s_wr_s[%0d]", tag, n), wr_s, n % 3);
        check($sformatf("%s_rd_s[%0d]", tag, n), rd_s, (n + 1) % 3);
        check($sformatf("%s_wr_c[%0d]", tag, n), wr_c, n % 6);
        check($sformatf("%s_rd_c[%0d]", tag, n), rd_c, (n + 1) % 6);
      end else begin
        check($sformatf("%s_idle_valid_b[%0d]", tag, cyc), valid_b, 0);
        check($sformatf("%s_idle_valid_s[%0d]", tag, cyc), valid_s, 0);
        check($sformatf("%s_idle_valid_c[%0d]", tag, cyc), valid_c, 0);
        check($sformatf("%s_idle_wr_b[%0d]", tag, cyc), wr_b, n % 3);
        check($sformatf("%s_idle_wr_c[%0d]", tag, cyc), wr_c, n % 6);
        check($sformatf("%s_idle_ch_c[%0d]", tag, cyc), ch_c, (n == 0) ? 0 : ((n - 1) % 48) % 3);
`ifdef PIXWIN_FRAME_STATUS_EN
        check($sformatf("%s_idle_fd_b[%0d]", tag, cyc), fd_b, 0);
`endif
      end
    end
    check({tag, "_budget"}, n, target);
    for (int f = 0; f < n / 25; f++) begin
      check($sformatf("%s_count_b[f%0d]", tag, f), cnt_b[f], 9);
      check($sformatf("%s_count_s[f%0d]", tag, f), cnt_s[f], 4);
    end
    for (int f = 0; f < n / 48; f++)
      check($sformatf("%s_count_c[f%0d]", tag, f), cnt_c[f], 12);
    if (n >= 13) check({tag, "_first_valid"}, first_v, 12);
  endtask

  initial begin
    #1;
    check_reset("por");
    @(posedge clk);
    #1;
    check_reset("por_hold");
    rst_n = 1'b1;

    run("cont", 100, 1'b0, 200);

    rst_n = 1'b0;
    #1;
    check_reset("rst2");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run("gaps", 60, 1'b1, 600);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run("pre", 17, 1'b0, 40);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    clk_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run("post", 13, 1'b0, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
